// File: rtl/pipeline_pkg.sv
// Shared types for the rv32i pipeline sequencer: state encoding and
// per-state output vectors {fetch, decode, exec, write, pc_hold, flush}.
package pipeline_pkg;

    typedef enum logic [3:0] {
        WARMUP_1   = 4'd0,
        WARMUP_2   = 4'd1,
        WARMUP_3   = 4'd2,
        RUN        = 4'd3,
        STALL_LOAD = 4'd4,
        FLUSH      = 4'd5,
        PAUSE      = 4'd6,
        HALT       = 4'd7
    } pipeline_t;

    localparam logic [5:0] OUT_WARMUP_1   = 6'b100000;
    localparam logic [5:0] OUT_WARMUP_2   = 6'b110000;
    localparam logic [5:0] OUT_WARMUP_3   = 6'b111000;
    localparam logic [5:0] OUT_RUN        = 6'b111100;
    localparam logic [5:0] OUT_STALL_LOAD = 6'b000110;
    localparam logic [5:0] OUT_FLUSH      = 6'b000001;
    localparam logic [5:0] OUT_PAUSE      = 6'b000010;
    localparam logic [5:0] OUT_HALT       = 6'b000010;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 4-stage pipeline: stage enables, PC hold,
// flush, warm-up, load-use stall, pause, halt and two perf counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_hazard,
    input  logic             br_taken,
    input  logic             pause_req,
    input  logic             halt,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             write_en,
    output logic             pc_hold,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    pipeline_t  state_q, state_d;
    pipeline_t  saved_q, saved_d;
    logic [1:0] cnt_q, cnt_d;
    logic [5:0] out_vec;
    logic       pause_ok;
    logic       hazard_ok;

    assign pause_ok  = (state_q == WARMUP_1) || (state_q == WARMUP_2) ||
                       (state_q == WARMUP_3) || (state_q == RUN);
    assign hazard_ok = (state_q == WARMUP_3) || (state_q == RUN);

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            HALT: state_d = HALT;
            PAUSE: begin
                if (halt) begin
                    state_d = HALT;
                end else if (!pause_req) begin
                    state_d = saved_q;
                end
            end
            FLUSH: state_d = halt ? HALT : WARMUP_1;
            default: begin
                if (halt) begin
                    state_d = HALT;
                end else if (br_taken) begin
                    state_d = FLUSH;
                end else if (state_q == STALL_LOAD) begin
                    // hazard and pause wait until the stall drains
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end else if (load_hazard && hazard_ok) begin
                    state_d = STALL_LOAD;
                    cnt_d   = STALL_INIT;
                end else if (pause_req && pause_ok) begin
                    state_d = PAUSE;
                    saved_d = state_q;
                end else begin
                    unique case (state_q)
                        WARMUP_1: state_d = WARMUP_2;
                        WARMUP_2: state_d = WARMUP_3;
                        default:  state_d = RUN;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WARMUP_1;
            saved_q <= WARMUP_1;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out_vec = OUT_HALT;
        unique case (state_q)
            WARMUP_1:   out_vec = OUT_WARMUP_1;
            WARMUP_2:   out_vec = OUT_WARMUP_2;
            WARMUP_3:   out_vec = OUT_WARMUP_3;
            RUN:        out_vec = OUT_RUN;
            STALL_LOAD: out_vec = OUT_STALL_LOAD;
            FLUSH:      out_vec = OUT_FLUSH;
            PAUSE:      out_vec = OUT_PAUSE;
            default:    out_vec = OUT_HALT;
        endcase
    end

    assign {fetch_en, decode_en, exec_en, write_en, pc_hold, flush} = out_vec;
    assign halted = (state_q == HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (state_q == STALL_LOAD),
        .q   (stall_cnt)
    );

    // counted on the edge that enters FLUSH
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((state_d == FLUSH) && (state_q != FLUSH)),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl: two instances (default and a narrow
// counter / longer stall variant) checked against a behavioural model.
module tb_pipeline_ctrl;

    localparam int L0 = 2;
    localparam int W0 = 32;
    localparam int L1 = 3;
    localparam int W1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load_hazard = 1'b0;
    logic br_taken = 1'b0;
    logic pause_req = 1'b0;
    logic halt = 1'b0;

    logic fe0, de0, ee0, we0, ph0, fl0, ha0;
    logic fe1, de1, ee1, we1, ph1, fl1, ha1;
    logic [W0-1:0] sc0, fc0;
    logic [W1-1:0] sc1, fc1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.LOAD_STALL_CYCLES(L0), .CNT_W(W0)) dut0 (
        .clk(clk), .rst(rst), .load_hazard(load_hazard),
        .br_taken(br_taken), .pause_req(pause_req), .halt(halt),
        .fetch_en(fe0), .decode_en(de0), .exec_en(ee0), .write_en(we0),
        .pc_hold(ph0), .flush(fl0), .halted(ha0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipeline_ctrl #(.LOAD_STALL_CYCLES(L1), .CNT_W(W1)) dut1 (
        .clk(clk), .rst(rst), .load_hazard(load_hazard),
        .br_taken(br_taken), .pause_req(pause_req), .halt(halt),
        .fetch_en(fe1), .decode_en(de1), .exec_en(ee1), .write_en(we1),
        .pc_hold(ph1), .flush(fl1), .halted(ha1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    // model: stage = number of active front stages (4 = running),
    // stall = stall cycles still to serve, plus flush/pause/halt flags
    int     m_stage[2];
    int     m_stall[2];
    bit     m_flush[2];
    bit     m_pause[2];
    bit     m_halt[2];
    longint m_sc[2];
    longint m_fc[2];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic longint sat_inc(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v < mx) ? v + 1 : v;
    endfunction

    function automatic logic [6:0] m_out(input int i);
        logic [3:0] en;
        if (m_halt[i])  return 7'b0000101;
        if (m_flush[i]) return 7'b0000010;
        if (m_pause[i]) return 7'b0000100;
        if (m_stall[i] > 0) return 7'b0001100;
        en = 4'b1111 << (4 - m_stage[i]);
        return {en, 3'b000};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_stage[i] = 1;
            m_stall[i] = 0;
            m_flush[i] = 0;
            m_pause[i] = 0;
            m_halt[i]  = 0;
            m_sc[i]    = 0;
            m_fc[i]    = 0;
        end
    endtask

    task automatic m_step(input int i, input int lcy, input int w,
                          input bit h, input bit b, input bit lh, input bit p);
        if (m_stall[i] > 0) m_sc[i] = sat_inc(m_sc[i], w);
        if (m_halt[i]) begin
        end else if (m_pause[i]) begin
            if (h) begin
                m_pause[i] = 0;
                m_halt[i] = 1;
            end else if (!p) begin
                m_pause[i] = 0;
            end
        end else if (m_flush[i]) begin
            m_flush[i] = 0;
            if (h) m_halt[i] = 1;
            else m_stage[i] = 1;
        end else if (h) begin
            m_stall[i] = 0;
            m_halt[i] = 1;
        end else if (b) begin
            m_stall[i] = 0;
            m_flush[i] = 1;
            m_fc[i] = sat_inc(m_fc[i], w);
        end else if (m_stall[i] > 0) begin
            m_stall[i]--;
        end else if (lh && m_stage[i] >= 3) begin
            m_stall[i] = lcy;
            m_stage[i] = 4;
        end else if (p) begin
            m_pause[i] = 1;
        end else if (m_stage[i] < 4) begin
            m_stage[i]++;
        end
    endtask

    task automatic compare();
        chk("out0", 64'({fe0, de0, ee0, we0, ph0, fl0, ha0}), 64'(m_out(0)));
        chk("stall_cnt0", 64'(sc0), 64'(m_sc[0]));
        chk("flush_cnt0", 64'(fc0), 64'(m_fc[0]));
        chk("out1", 64'({fe1, de1, ee1, we1, ph1, fl1, ha1}), 64'(m_out(1)));
        chk("stall_cnt1", 64'(sc1), 64'(m_sc[1]));
        chk("flush_cnt1", 64'(fc1), 64'(m_fc[1]));
    endtask

    // drive inputs after negedge, clock, then check after the next negedge
    task automatic cyc(input bit h, input bit b, input bit lh, input bit p);
        halt = h;
        br_taken = b;
        load_hazard = lh;
        pause_req = p;
        @(posedge clk);
        m_step(0, L0, W0, h, b, lh, p);
        m_step(1, L1, W1, h, b, lh, p);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        halt = 0;
        br_taken = 0;
        load_hazard = 0;
        pause_req = 0;
        rst = 1'b1;
        #1;
        m_reset();
        compare();
        @(negedge clk);
        rst = 1'b0;
        compare();
    endtask

    initial begin
        bit p_lvl;
        @(negedge clk);
        do_reset();
        idle(6);

        cyc(0, 0, 1, 0);
        idle(5);
        chk("stall_after_pulse", 64'(sc0), 64'(L0));

        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        idle(6);

        cyc(0, 1, 1, 0);
        idle(5);
        chk("flush_total", 64'(fc0), 64'd2);

        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        idle(4);

        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("halted_sticky", 64'(ha0), 64'd1);
        do_reset();

        idle(4);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 1, 0);
            idle(4);
        end
        chk("stall_sat_w4", 64'(sc1), 64'd15);

        p_lvl = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk);
                do_reset();
            end
            if ($urandom_range(0, 7) == 0) p_lvl = ~p_lvl;
            cyc($urandom_range(0, 399) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0,
                p_lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
